// File: rtl/zero_scan_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : zero_scan_ctrl_if
// Brief    : Start/ready/done handshake bundle for the sequential zero scanner.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface zero_scan_ctrl_if;
    logic        start;  // scan request, honoured only while ready
    logic [63:0] in;     // operand, captured on the accepting edge
    logic        is32;   // 1 = W operand, only bits [31:0] are scanned
    logic        ready;  // controller idle
    logic        done;   // one-cycle result-valid pulse
    logic        zero;   // scanned bits were all zero
    logic [2:0]  count;  // chunks examined by the last scan (1..4)

    modport master (
        output start, in, is32,
        input  ready, done, zero, count
    );

    modport slave (
        input  start, in, is32,
        output ready, done, zero, count
    );
endinterface
`default_nettype wire

// File: rtl/zero_scan_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : zero_scan_ctrl (+ zero16 slice detector)
// Brief    : Time-shares one 16-bit zero detector over the four chunks of a
//            64-bit operand, one chunk per clock, with early exit on the
//            first non-zero chunk. Supports X (64-bit) and W (32-bit) widths.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------

module zero16 (
    input  wire logic [15:0] in_i,
    output logic             zero_o
);
    assign zero_o = ~|in_i;
endmodule

module zero_scan_ctrl (
    input  wire logic         clk,
    input  wire logic         reset,
    zero_scan_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [63:0] op_q, op_d;
    logic        is32_q, is32_d;
    logic        zero_q, zero_d;
    logic [2:0]  count_q, count_d;

    logic [15:0] w_chunk;
    logic        w_slice_zero;
    logic [1:0]  w_last;
    logic [2:0]  w_count_next;

    // Select the chunk under examination from the captured operand
    always_comb begin
        w_chunk = op_q[15:0];
        case (idx_q)
            2'd0: w_chunk = op_q[15:0];
            2'd1: w_chunk = op_q[31:16];
            2'd2: w_chunk = op_q[47:32];
            2'd3: w_chunk = op_q[63:48];
            default: w_chunk = op_q[15:0];
        endcase
    end

    zero16 u_zero16 (
        .in_i   (w_chunk),
        .zero_o (w_slice_zero)
    );

    // W operands stop after chunk 1, so bits [63:32] are never examined
    assign w_last       = is32_q ? 2'd1 : 2'd3;
    assign w_count_next = {1'b0, idx_q} + 3'd1;

    // Next-state and datapath update decode
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        is32_d  = is32_q;
        zero_d  = zero_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_SCAN;
                    idx_d   = 2'd0;
                    op_d    = bus.in;
                    is32_d  = bus.is32;
                    zero_d  = 1'b0;
                    count_d = 3'd0;
                end
            end
            S_SCAN: begin
                if (!w_slice_zero) begin
                    zero_d  = 1'b0;
                    count_d = w_count_next;
                    state_d = S_DONE;
                end else if (idx_q == w_last) begin
                    zero_d  = 1'b1;
                    count_d = w_count_next;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            S_DONE: begin
                // start is deliberately ignored here; requester retries in IDLE
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any scan and drops captured data
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            op_q    <= 64'd0;
            is32_q  <= 1'b0;
            zero_q  <= 1'b0;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            is32_q  <= is32_d;
            zero_q  <= zero_d;
            count_q <= count_d;
        end
    end

    assign bus.ready = (state_q == S_IDLE);
    assign bus.done  = (state_q == S_DONE);
    assign bus.zero  = zero_q;
    assign bus.count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_zero_scan_ctrl.sv
`timescale 1ps/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_zero_scan_ctrl
// Brief    : Directed self-checking bench for zero_scan_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_zero_scan_ctrl;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    zero_scan_ctrl_if bus ();

    zero_scan_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // 1000 ps clock; inputs driven and outputs sampled on the falling edge
    initial clk = 1'b0;
    always #500 clk = ~clk;

    // Run one scan; exp_lat is the number of rising edges after the accepting
    // edge at which done is first seen (equals the expected count).
    task automatic do_scan(input string name, input logic [63:0] data,
                           input logic w, input logic exp_zero,
                           input logic [2:0] exp_count, input int exp_lat,
                           input logic chg_mid);
        int k;
        bit seen;
        @(negedge clk);
        if (bus.ready !== 1'b1) begin
            $display("FAIL %s ready_before_start: got %b want 1", name, bus.ready);
            errors++;
        end
        checks++;
        bus.start = 1'b1;
        bus.in    = data;
        bus.is32  = w;
        @(negedge clk);  // accepting edge E0 has passed
        bus.start = 1'b0;
        if (bus.ready !== 1'b0 || bus.zero !== 1'b0 || bus.count !== 3'd0) begin
            $display("FAIL %s accept: ready=%b zero=%b count=%0d want 0/0/0",
                     name, bus.ready, bus.zero, bus.count);
            errors++;
        end
        checks++;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 10) begin
            @(negedge clk);
            k++;
            if (chg_mid && k == 1) begin
                bus.in   = 64'd0;
                bus.is32 = ~w;
            end
            if (bus.done === 1'b1) seen = 1'b1;
        end
        if (!seen || k != exp_lat) begin
            $display("FAIL %s latency: got %0d seen=%b want %0d", name, k, seen, exp_lat);
            errors++;
        end
        checks++;
        if (bus.zero !== exp_zero || bus.count !== exp_count) begin
            $display("FAIL %s result: zero=%b count=%0d want zero=%b count=%0d",
                     name, bus.zero, bus.count, exp_zero, exp_count);
            errors++;
        end
        checks++;
        @(negedge clk);
        if (bus.done !== 1'b0 || bus.ready !== 1'b1 ||
            bus.zero !== exp_zero || bus.count !== exp_count) begin
            $display("FAIL %s after_done: done=%b ready=%b zero=%b count=%0d want 0/1/%b/%0d",
                     name, bus.done, bus.ready, bus.zero, bus.count, exp_zero, exp_count);
            errors++;
        end
        checks++;
        bus.in   = 64'd0;
        bus.is32 = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.in    = 64'd0;
        bus.is32  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 ||
            bus.zero !== 1'b0 || bus.count !== 3'd0) begin
            $display("FAIL reset_state: ready=%b done=%b zero=%b count=%0d want 1/0/0/0",
                     bus.ready, bus.done, bus.zero, bus.count);
            errors++;
        end
        checks++;
        bus.start = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic test_all_zero_x();
        do_scan("all_zero_x", 64'h0, 1'b0, 1'b1, 3'd4, 4, 1'b0);
    endtask

    task automatic test_early_exit();
        do_scan("early_exit", 64'h0000_0000_0000_0004, 1'b0, 1'b0, 3'd1, 1, 1'b0);
    endtask

    task automatic test_w_mode();
        do_scan("top_bit_x", 64'h8000_0000_0000_0000, 1'b0, 1'b0, 3'd4, 4, 1'b0);
        do_scan("w_ignores_hi", 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b1, 3'd2, 2, 1'b0);
        do_scan("w_chunk1", 64'h0000_0000_0001_0000, 1'b1, 1'b0, 3'd2, 2, 1'b0);
    endtask

    task automatic test_mid_scan_change();
        do_scan("chunk2_x", 64'h0000_0755_0000_0000, 1'b0, 1'b0, 3'd3, 3, 1'b0);
        do_scan("mid_change", 64'h0000_0755_0000_0000, 1'b0, 1'b0, 3'd3, 3, 1'b1);
    endtask

    // start held high: accepts at E0 and E6, done visible after E4 and E10
    task automatic test_back_to_back();
        int pulses;
        int first_k;
        int second_k;
        int t;
        pulses   = 0;
        first_k  = -1;
        second_k = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = 64'd0;
        bus.is32  = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                pulses++;
                if (first_k < 0) first_k = k;
                else if (second_k < 0) second_k = k;
            end
        end
        bus.start = 1'b0;
        if (pulses != 2 || first_k != 4 || second_k != 10) begin
            $display("FAIL back_to_back: pulses=%0d at %0d,%0d want 2 at 4,10",
                     pulses, first_k, second_k);
            errors++;
        end
        checks++;
        t = 0;
        while (bus.ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (bus.ready !== 1'b1 || bus.zero !== 1'b1 || bus.count !== 3'd4) begin
            $display("FAIL back_to_back_drain: ready=%b zero=%b count=%0d want 1/1/4",
                     bus.ready, bus.zero, bus.count);
            errors++;
        end
        checks++;
    endtask

    // start pulses inside SCAN and DONE must not launch another scan
    task automatic test_ignored_start();
        int pulses;
        pulses = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = 64'd0;
        bus.is32  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus.start = (k == 2 || k == 4);
            if (bus.done === 1'b1) pulses++;
        end
        bus.start = 1'b0;
        if (pulses != 1 || bus.ready !== 1'b1) begin
            $display("FAIL ignored_start: pulses=%0d ready=%b want 1/1", pulses, bus.ready);
            errors++;
        end
        checks++;
    endtask

    task automatic test_reset_mid_scan();
        int pulses;
        pulses = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = 64'd0;
        bus.is32  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 ||
            bus.zero !== 1'b0 || bus.count !== 3'd0) begin
            $display("FAIL reset_mid_scan: ready=%b done=%b zero=%b count=%0d want 1/0/0/0",
                     bus.ready, bus.done, bus.zero, bus.count);
            errors++;
        end
        checks++;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        if (pulses != 0) begin
            $display("FAIL reset_no_done: pulses=%0d want 0", pulses);
            errors++;
        end
        checks++;
        do_scan("after_reset", 64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 3'd1, 1, 1'b0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.in    = 64'd0;
        bus.is32  = 1'b0;
        test_reset();
        test_all_zero_x();
        test_early_exit();
        test_w_mode();
        test_mid_scan_change();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
